// File: rtl/riscv_pkg.sv
// riscv_pkg: loader state encoding and default instruction-memory geometry.
package riscv_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} loader_state_t;
    localparam int MEM_DEPTH_DEF = 32;
    localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/program_loader.sv
// program_loader: assembles a little-endian byte stream into instruction-memory word writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module program_loader
    import riscv_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    loader_state_t state, state_nxt;
    logic [ADDR_W:0] len, word_cnt;
    logic [1:0] byte_cnt;
    logic [23:0] word_buf;
    logic accept, go, word_end, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign byte_ready = state == LOAD || state == CHECK;
    // The final write lands after the state has left LOAD, so hold covers it too.
    assign cpu_hold = byte_ready || wr_en;
    assign done = state == DONE;
    assign error = state == ERR;
    assign accept = byte_valid && byte_ready;
    assign go = start && !byte_ready;
    assign word_end = accept && state == LOAD && byte_cnt == 2'd3;
    assign last_word = word_end && word_cnt + ONE == len;

    always_comb begin
        state_nxt = state;
        if (go)
            state_nxt = load_len == '0 ? DONE : load_len > DEPTH ? ERR : LOAD;
`ifdef LOADER_CHECKSUM_EN
        else if (last_word)
            state_nxt = CHECK;
        else if (accept && state == CHECK)
            state_nxt = byte_data == csum ? DONE : ERR;
`else
        else if (last_word)
            state_nxt = DONE;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= word_end;
            if (go) begin
                len <= load_len;
                word_cnt <= '0;
                byte_cnt <= '0;
                word_buf <= '0;
            end else if (accept && state == LOAD) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= {byte_data, word_buf[23:8]};
                if (word_end) begin
                    wr_addr <= word_cnt[ADDR_W-1:0];
                    wr_data <= {byte_data, word_buf};
                    word_cnt <= word_cnt + ONE;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n || go)
            csum <= '0;
        else if (accept && state == LOAD)
            csum <= csum ^ byte_data;
    end
`endif
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, meaning the number of 32-bit instruction words in the target instruction memory.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the word-address width, equal to clog2(MEM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port load_len  input  ADDR_W+1  number of words to load, sampled with start.
REQ-007 SHALL have port byte_valid  input  1  byte_data is valid.
REQ-008 SHALL have port byte_data  input  8  program byte stream, in little-endian order within each word.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-011 SHALL have port wr_addr  output  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port wr_data  output  32  instruction word to write.
REQ-013 SHALL have port cpu_hold  output  1  holds the CPU PC/fetch while the memory is being rewritten.
REQ-014 SHALL have port done  output  1  last load completed successfully; level signal.
REQ-015 SHALL have port error  output  1  last load failed; level signal.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, DONE and ERR; CHECK is reachable only when LOADER_CHECKSUM_EN is defined.
REQ-017 SHALL, on start in IDLE, DONE or ERR, latch load_len, clear the word and byte counters, and go to LOAD; if load_len==0, it SHALL go to DONE instead; if load_len>MEM_DEPTH, it SHALL go to ERR.
REQ-018 SHALL ignore start while in LOAD or CHECK.
REQ-019 SHALL drive byte_ready=1 only in LOAD and CHECK; a byte is accepted only when byte_valid and byte_ready are both 1.
REQ-020 SHALL place the k-th accepted byte of a word (k=0..3) into bits [8k+7:8k].
REQ-021 SHALL, when the 4th byte of word n is accepted in cycle N, assert wr_en for exactly cycle N+1 with wr_addr=n and wr_data=the assembled word (registered outputs, 1-cycle latency).
REQ-022 SHALL wrap the byte counter from 3 to 0 and increment the word counter on each completed word; the word counter SHALL never exceed load_len.
REQ-023 SHALL, on completion of word load_len-1, go to DONE (or to CHECK when LOADER_CHECKSUM_EN is defined) in the same cycle that wr_en is asserted.
REQ-024 SHALL drive cpu_hold=1 exactly while the state is LOAD or CHECK, including the cycle of the final wr_en.
REQ-025 SHALL drive done=1 only in DONE and error=1 only in ERR; both SHALL clear on the cycle after an accepted start.
REQ-026 SHALL tolerate any number of byte_valid=0 gap cycles without changing state or counters.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, enter IDLE with counters=0, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0 and error=0.
REQ-028 SHALL abandon a load in progress on reset mid-load, without asserting wr_en after reset and without preserving any partial word.

Configuration
REQ-029 SHALL, when LOADER_CHECKSUM_EN is defined, keep a running XOR of all accepted data bytes and, in CHECK, accept one extra byte: equal to the XOR -> DONE, different -> ERR; words already written remain written.
REQ-030 SHALL, when LOADER_CHECKSUM_EN is undefined, contain no checksum register and go directly to DONE after the last word.

Structure
REQ-031 SHALL take the state encoding enum and the MEM_DEPTH/ADDR_W defaults from a shared package named riscv_pkg.
REQ-032 SHALL remain a single module with no sub-module; the byte-to-word assembler is inline.

Verification
REQ-033 SHALL cover: load_len=2, bytes 13,00,00,00,93,00,10,00 -> wr_en at addr0 data 00000013, then addr1 data 00100093, then done=1 and cpu_hold=0.
REQ-034 SHALL cover: load_len=1 with byte_valid gaps of 3 cycles between bytes -> a single wr_en with the correct word, and cpu_hold held high throughout.
REQ-035 SHALL cover: load_len=0 -> done=1 on the next cycle and no wr_en; load_len=33 -> error=1 and no wr_en.
REQ-036 SHALL cover: rst_n=0 after 6 bytes of a 2-word load -> IDLE with all outputs 0, and no second write.
REQ-037 SHALL cover: start pulsed mid-load -> ignored; start issued from DONE -> a new load beginning at addr0.
REQ-038 SHALL cover, with LOADER_CHECKSUM_EN defined: bytes 13,00,00,00 plus checksum 13 -> done=1; the same bytes plus checksum 14 -> error=1.
